// File: rtl/uart_cmd_sequencer_if.sv
// Signal bundle between the UART receiver, the command sequencer and the servo PWM stage.
// The master side is the environment (UART RX + PWM stage); the slave side is the sequencer.
interface uart_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          moving;
  logic [2:0]    state_desired;
  logic          uart_command_valid;
  logic [CW-1:0] queue_count;
  logic          bad_char;
  logic          overflow;
  logic          cmd_dropped;

  modport master (
    output rx_data, rx_valid, moving,
    input  state_desired, uart_command_valid, queue_count, bad_char, overflow, cmd_dropped
  );

  modport slave (
    input  rx_data, rx_valid, moving,
    output state_desired, uart_command_valid, queue_count, bad_char, overflow, cmd_dropped
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Decodes UART command letters into a small FIFO and issues them one at a time to the
// servo PWM stage, tracking its moving flag for acknowledge and completion.
module uart_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int VALID_HOLD  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_cmd_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(VALID_HOLD + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(VALID_HOLD - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // OR-ing 0x20 folds upper case onto lower case; only letter pairs can land on a command code.
  function automatic logic [3:0] decode_cmd(input logic [7:0] b);
    logic [3:0] r;
    case (b | 8'h20)
      8'h69:   r = {1'b1, 3'b001};
      8'h70:   r = {1'b1, 3'b010};
      8'h65:   r = {1'b1, 3'b011};
      8'h74:   r = {1'b1, 3'b100};
      8'h75:   r = {1'b1, 3'b101};
      8'h64:   r = {1'b1, 3'b110};
      default: r = {1'b0, 3'b000};
    endcase
    return r;
  endfunction

  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
  endfunction

  logic [2:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          bad_q, bad_d, ovf_q, ovf_d;
  logic [3:0]    dec_s;
  logic          push_s, pop_s;

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [2:0]    sd_q, sd_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;

  // Decode and FIFO push/overflow decisions; a push into a full FIFO survives only alongside a pop.
  always_comb begin
    dec_s   = decode_cmd(bus.rx_data);
    push_s  = 1'b0;
    ovf_d   = 1'b0;
    bad_d   = bus.rx_valid && !dec_s[3] && !is_filler(bus.rx_data);
    if (bus.rx_valid && dec_s[3]) begin
      if ((count_q != FULL_COUNT) || pop_s) begin
        push_s = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  // FIFO storage, pointers, occupancy and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'b000;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      bad_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= dec_s[2:0];
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      bad_q   <= bad_d;
      ovf_q   <= ovf_d;
    end
  end

  // Issue FSM next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sd_d    = sd_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != {CW{1'b0}}) && !bus.moving) begin
          pop_s   = 1'b1;
          sd_d    = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (hold_q == {HW{1'b0}}) begin
          valid_d = 1'b0;
          cnt_d   = {TW{1'b0}};
          state_d = S_WAIT_ACK;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_WAIT_ACK: begin
        if (bus.moving) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.moving) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Issue FSM state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      sd_q    <= 3'b000;
      hold_q  <= {HW{1'b0}};
      cnt_q   <= {TW{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sd_q    <= sd_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.state_desired      = sd_q;
  assign bus.uart_command_valid = valid_q;
  assign bus.queue_count        = count_q;
  assign bus.bad_char           = bad_q;
  assign bus.overflow           = ovf_q;
  assign bus.cmd_dropped        = drop_q;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: reset, decode, queueing, overflow, ack timeout
// and reset during issue, with hand-computed expectations.
module tb_uart_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_cmd_sequencer_if #(.DEPTH(4)) bus ();

  uart_cmd_sequencer #(.DEPTH(4), .VALID_HOLD(2), .ACK_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int bad_cnt = 0, ovf_cnt = 0, drop_cnt = 0;
  logic prev_valid = 1'b0;
  logic [2:0] issued [$];

  // Pulse counters and issue log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.bad_char)    bad_cnt  <= bad_cnt + 1;
    if (bus.overflow)    ovf_cnt  <= ovf_cnt + 1;
    if (bus.cmd_dropped) drop_cnt <= drop_cnt + 1;
    if (bus.uart_command_valid && !prev_valid) issued.push_back(bus.state_desired);
    prev_valid <= bus.uart_command_valid;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // PWM model: moving rises 2 cycles after valid rises, stays up for hold cycles.
  task automatic serve_one(input string tag, input int hold);
    int waited;
    waited = 0;
    while (!bus.uart_command_valid && waited < 40) begin
      tick();
      waited++;
    end
    check_eq({tag, "_issue_seen"}, int'(bus.uart_command_valid), 1);
    tick();
    bus.moving = 1'b1;
    tick(hold);
    bus.moving = 1'b0;
    tick();
  endtask

  int b0, o0, d0, i0, gap, any_v, any_d;

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.moving   = 1'b0;

    // 1: reset values, single 't' with acknowledged move
    tick(2);
    check_eq("rst_valid", int'(bus.uart_command_valid), 0);
    check_eq("rst_sd",    int'(bus.state_desired), 0);
    check_eq("rst_count", int'(bus.queue_count), 0);
    check_eq("rst_pulses", int'({bus.bad_char, bus.overflow, bus.cmd_dropped}), 0);
    rst_n = 1'b1;
    tick();
    send(8'h74);
    check_eq("t1_push_count", int'(bus.queue_count), 1);
    check_eq("t1_valid_n1",   int'(bus.uart_command_valid), 0);
    tick();
    check_eq("t1_valid_n2", int'(bus.uart_command_valid), 1);
    check_eq("t1_sd_n2",    int'(bus.state_desired), 4);
    check_eq("t1_count_n2", int'(bus.queue_count), 0);
    tick();
    check_eq("t1_valid_n3", int'(bus.uart_command_valid), 1);
    bus.moving = 1'b1;
    tick();
    check_eq("t1_valid_n4", int'(bus.uart_command_valid), 0);
    any_v = 0; any_d = 0;
    for (int k = 0; k < 49; k++) begin
      tick();
      any_v |= int'(bus.uart_command_valid);
      any_d |= int'(bus.cmd_dropped);
    end
    bus.moving = 1'b0;
    tick(3);
    check_eq("t1_no_reissue", any_v, 0);
    check_eq("t1_no_drop",    any_d, 0);
    check_eq("t1_count_end",  int'(bus.queue_count), 0);
    check_eq("t1_sd_held",    int'(bus.state_desired), 4);

    // 2: "p\r\ne" while moving, then two ordered issues
    b0 = bad_cnt; i0 = issued.size();
    bus.moving = 1'b1;
    send(8'h70); send(8'h0D); send(8'h0A); send(8'h65);
    tick();
    check_eq("t2_count",  int'(bus.queue_count), 2);
    check_eq("t2_no_bad", bad_cnt - b0, 0);
    check_eq("t2_no_issue_moving", issued.size() - i0, 0);
    bus.moving = 1'b0;
    tick();
    check_eq("t2_valid_p", int'(bus.uart_command_valid), 1);
    check_eq("t2_sd_p",    int'(bus.state_desired), 2);
    check_eq("t2_count_p", int'(bus.queue_count), 1);
    tick();
    bus.moving = 1'b1;
    tick();
    gap = (bus.uart_command_valid == 1'b0) ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!bus.uart_command_valid) gap++;
    end
    bus.moving = 1'b0;
    tick();
    check_eq("t2_idle_after_fall", int'(bus.uart_command_valid), 0);
    if (!bus.uart_command_valid) gap++;
    tick();
    check_eq("t2_valid_e", int'(bus.uart_command_valid), 1);
    check_eq("t2_sd_e",    int'(bus.state_desired), 3);
    check_eq("t2_gap_ge2", int'(gap >= 2), 1);
    tick();
    bus.moving = 1'b1;
    tick(5);
    bus.moving = 1'b0;
    tick(3);
    check_eq("t2_count_end", int'(bus.queue_count), 0);

    // 3: unrecognised bytes
    b0 = bad_cnt; i0 = issued.size();
    send(8'h78);
    check_eq("t3_bad_pulse_x", int'(bus.bad_char), 1);
    send(8'h51);
    check_eq("t3_bad_pulse_Q", int'(bus.bad_char), 1);
    tick();
    check_eq("t3_bad_low", int'(bus.bad_char), 0);
    tick(3);
    check_eq("t3_bad_cnt",  bad_cnt - b0, 2);
    check_eq("t3_count",    int'(bus.queue_count), 0);
    check_eq("t3_no_issue", issued.size() - i0, 0);

    // 4: overflow with DEPTH=4, then in-order drain
    o0 = ovf_cnt; i0 = issued.size();
    bus.moving = 1'b1;
    send(8'h49); send(8'h70); send(8'h65); send(8'h54);
    check_eq("t4_count_full", int'(bus.queue_count), 4);
    check_eq("t4_no_ovf_yet", int'(bus.overflow), 0);
    send(8'h75);
    check_eq("t4_ovf_pulse", int'(bus.overflow), 1);
    check_eq("t4_count_kept", int'(bus.queue_count), 4);
    tick();
    bus.moving = 1'b0;
    for (int k = 0; k < 4; k++) serve_one("t4", 5);
    tick(10);
    check_eq("t4_ovf_cnt",   ovf_cnt - o0, 1);
    check_eq("t4_n_issued",  issued.size() - i0, 4);
    if (issued.size() - i0 == 4) begin
      check_eq("t4_order0", int'(issued[i0]),     1);
      check_eq("t4_order1", int'(issued[i0 + 1]), 2);
      check_eq("t4_order2", int'(issued[i0 + 2]), 3);
      check_eq("t4_order3", int'(issued[i0 + 3]), 4);
    end
    check_eq("t4_count_end", int'(bus.queue_count), 0);

    // 5: no ack -> cmd_dropped 16 cycles after valid falls, next command follows
    d0 = drop_cnt;
    send(8'h75);
    send(8'h69);
    check_eq("t5_valid_u", int'(bus.uart_command_valid), 1);
    check_eq("t5_sd_u",    int'(bus.state_desired), 5);
    check_eq("t5_count",   int'(bus.queue_count), 1);
    tick();
    tick();
    check_eq("t5_valid_fell", int'(bus.uart_command_valid), 0);
    any_d = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      any_d |= int'(bus.cmd_dropped);
    end
    check_eq("t5_no_early_drop", any_d, 0);
    tick();
    check_eq("t5_drop_pulse", int'(bus.cmd_dropped), 1);
    tick();
    check_eq("t5_drop_one_cycle", int'(bus.cmd_dropped), 0);
    check_eq("t5_next_valid", int'(bus.uart_command_valid), 1);
    check_eq("t5_next_sd",    int'(bus.state_desired), 1);
    tick(25);
    check_eq("t5_drop_cnt", drop_cnt - d0, 2);

    // 6: reset during issue with 2 entries queued
    bus.moving = 1'b1;
    send(8'h69); send(8'h70); send(8'h65);
    bus.moving = 1'b0;
    tick();
    check_eq("t6_in_issue", int'(bus.uart_command_valid), 1);
    check_eq("t6_count2",   int'(bus.queue_count), 2);
    rst_n = 1'b0;
    tick();
    check_eq("t6_rst_valid", int'(bus.uart_command_valid), 0);
    check_eq("t6_rst_count", int'(bus.queue_count), 0);
    check_eq("t6_rst_sd",    int'(bus.state_desired), 0);
    rst_n = 1'b1;
    i0 = issued.size();
    tick(10);
    check_eq("t6_no_issue", issued.size() - i0, 0);
    check_eq("t6_count_end", int'(bus.queue_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
Sits directly upstream of the servo PWM stage. It takes received UART bytes, decodes single-letter position commands into the 3-bit state_desired code, and queues them in a small FIFO. It issues one command at a time to the PWM stage as a clean uart_command_valid pulse, and only when the servo is not moving. After issuing, it tracks the PWM stage's moving flag for acknowledge and completion, so that commands are never lost against the PWM stage's edge-detect and !moving gating.

Parameters:
DEPTH, 4, command FIFO entries; must be a power of 2, minimum 2.
VALID_HOLD, 2, cycles uart_command_valid stays high per issue; minimum 1.
ACK_TIMEOUT, 16, cycles to wait for moving to rise after valid drops before treating the command as rejected.

Ports:
clk  in  1  system clock, 27 MHz
rst_n  in  1  synchronous active-low reset
rx_data  in  8  received byte from UART RX
rx_valid  in  1  one-cycle strobe; rx_data valid
moving  in  1  PWM stage movement-active flag
state_desired  out  3  command code to PWM stage
uart_command_valid  out  1  command strobe to PWM stage
queue_count  out  log2(DEPTH)+1  FIFO occupancy
bad_char  out  1  one-cycle pulse: unrecognised byte received
overflow  out  1  one-cycle pulse: valid command dropped because FIFO was full
cmd_dropped  out  1  one-cycle pulse: issued command got no ack within ACK_TIMEOUT

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO empty, FSM goes to S_IDLE, and all outputs read 0, including state_desired=3'b000 and queue_count=0. A reset mid-issue drops valid on the next edge.
- Decode, case-insensitive:
  - 'i' maps to 3'b001; 'p' to 3'b010; 'e' to 3'b011; 't' to 3'b100; 'u' to 3'b101; 'd' to 3'b110.
  - 0x0D, 0x0A and 0x20 are ignored silently, with no pulse.
  - Any other byte is not queued and raises bad_char for 1 cycle, on the cycle after the rx_valid edge.
- FIFO behaviour:
  - A push occurs on a decoded rx_valid.
  - A pop occurs on the S_IDLE to S_ISSUE transition.
  - When full, a push is accepted only if a pop happens in the same cycle; otherwise the byte is dropped and overflow pulses for 1 cycle.
  - A simultaneous push and pop on an empty FIFO cannot occur, because a pop requires a non-empty FIFO at the decision cycle.
  - Pointers wrap modulo DEPTH. queue_count is registered and updates on the same edge as the push or pop.
- FSM:
  - S_IDLE: if FIFO is non-empty and moving=0, register state_desired from the FIFO head, pop, set uart_command_valid=1, load the hold counter, and go to S_ISSUE. If moving=1, wait.
  - S_ISSUE: valid stays high for exactly VALID_HOLD cycles and state_desired is stable throughout. Then valid drops to 0, the timeout counter is cleared, and the FSM goes to S_WAIT_ACK.
  - S_WAIT_ACK:
    - moving=1 takes the FSM to S_WAIT_DONE.
    - Otherwise the counter increments. When it reaches ACK_TIMEOUT-1, cmd_dropped pulses for 1 cycle and the FSM goes to S_IDLE. This covers 'u' at top or 'd' at idle, which the PWM stage ignores.
  - S_WAIT_DONE: moving=0 takes the FSM to S_IDLE.
- Issue spacing: uart_command_valid is guaranteed low for at least 2 cycles between issues (S_WAIT_ACK plus S_IDLE), so the PWM stage always sees a fresh rising edge.
- state_desired holds its last value after an issue. It changes only on the cycle valid rises.
- Latency: a byte on rx_valid at cycle N, with an empty FIFO, S_IDLE and moving=0, pushes at edge N+1, and valid rises at edge N+2.
- moving rising during S_ISSUE is legal (PWM latency is 2 cycles). S_WAIT_ACK then sees moving=1 immediately.
- rx_valid is accepted in every state. Decoding and queuing are independent of the FSM.

Test Plan:
1. Reset, then send 't' with moving held 0 → valid high edges N+2..N+3 with state_desired=3'b100; model asserts moving 2 cycles after valid rises for 50 cycles → FSM returns to S_IDLE one cycle after moving falls; queue_count ends at 0.
2. Send "p\r\ne" back-to-back with moving=1 → queue_count=2, no bad_char; release moving → issues 3'b010, then after that move completes issues 3'b011; valid low for ≥2 cycles between the two issues.
3. Send 'x' then 'Q' → bad_char pulses twice, queue_count stays 0, valid never rises.
4. Hold moving=1 and send 5 valid commands with DEPTH=4 → queue_count=4, overflow pulses once on the 5th; release moving → exactly the first 4 are issued, in order.
5. Send 'u' with a PWM model that never raises moving → valid pulses for 2 cycles, then cmd_dropped pulses exactly 16 cycles after valid falls, and the next queued command issues.
6. Assert rst_n=0 during S_ISSUE with 2 entries queued → next edge: valid=0, queue_count=0, state_desired=0; after release, no command issues without new bytes.
